fft_peak_to_freq: RTL and testbench

FFT_PEAK_TO_FREQ -- requirements
Module: fft_peak_to_freq

---
 rtl/fft_pkg.sv | 38 +++
 rtl/freq_avg.sv | 51 +++++
 rtl/fft_peak_to_freq.sv | 139 +++++++++++++
 tb/tb_fft_peak_to_freq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared defaults and helpers for the FFT peak-to-frequency path.
//   NSAMPLES_DEF / NBITS_DEF : FFT window length and bin-index width
//   W_DEF                    : peak magnitude width
//   FSHZ_DEF                 : sample rate in Hz
//   state_t, ST_EMPTY/TRACK  : lock FSM encoding
//   bitrev()                 : reverse the low n bits of a bin index
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int NSAMPLES_DEF = 1024;
    localparam int NBITS_DEF    = $clog2(NSAMPLES_DEF);
    localparam int W_DEF        = 33;
    localparam int FSHZ_DEF     = 48000;

    // Lock FSM: EMPTY = no history held, TRACK = history valid.
    typedef logic [0:0] state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_TRACK = 1'b1;

    // Reverse the low n bits of k; bits at and above n come back zero.
    // Shift-based so no bit index depends on n.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int n);
        logic [31:0] r;
        logic [31:0] s;
        r = '0;
        s = k;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r = {r[30:0], s[0]};
                s = {1'b0, s[31:1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_avg.sv
// -----------------------------------------------------------------------------
// freq_avg
// AvgN-deep moving average of 16-bit frequency samples, built from a circular
// history buffer and a running sum.
//   clk, reset  : clock, async active-high reset
//   preload_i   : load every slot and the sum with sample_i (first window)
//   update_i    : replace the oldest slot with sample_i
//   sample_i    : new raw frequency (Hz)
//   avg_o       : combinational result for this cycle's preload/update,
//                 registered by the caller on the same edge
// -----------------------------------------------------------------------------
module freq_avg #(
    parameter int AvgN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        preload_i,
    input  logic        update_i,
    input  logic [15:0] sample_i,
    output logic [15:0] avg_o
);

    localparam int L  = $clog2(AvgN);
    localparam int SW = 16 + L;

    logic [15:0]   hist_q [AvgN];
    logic [L-1:0]  ptr_q;
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;

    // sum_q always covers hist_q exactly, so the subtraction cannot underflow.
    assign sum_d = sum_q - SW'(hist_q[ptr_q]) + SW'(sample_i);
    assign avg_o = preload_i ? sample_i : 16'(sum_d >> L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AvgN; i++) hist_q[i] <= '0;
            ptr_q <= '0;
            sum_q <= '0;
        end else if (preload_i) begin
            for (int i = 0; i < AvgN; i++) hist_q[i] <= sample_i;
            ptr_q <= '0;
            sum_q <= SW'(sample_i) << L;
        end else if (update_i) begin
            hist_q[ptr_q] <= sample_i;
            ptr_q         <= ptr_q + L'(1);  // AvgN is a power of two: wraps naturally
            sum_q         <= sum_d;
        end
    end

endmodule

// File: rtl/fft_peak_to_freq.sv
// -----------------------------------------------------------------------------
// fft_peak_to_freq
// Converts an FFT peak (bit-reversed bin index + magnitude) to a frequency in
// Hz, rejects weak peaks, and tracks lock across windows.
// Three-stage pipeline, one window per cycle:
//   S1: bit-reverse index, compare magnitude with threshold
//   S2: freq_raw = (k_nat * FsHz) >> NBits
//   S3: lock FSM, optional smoothing, output register
// Optional feature: define FFT_FREQ_SMOOTH_EN to average the last AvgN
// accepted windows; otherwise freq_hz is the raw per-window frequency.
// Ports:
//   clk, reset        : clock, async active-high reset
//   peak, peak_k      : peak magnitude and bit-reversed bin index
//   peak_valid        : strobe qualifying peak/peak_k/thresh
//   thresh            : minimum accepted magnitude
//   freq_hz           : (smoothed) frequency, holds between updates
//   freq_valid        : strobe, 3 cycles after an accepted peak_valid
//   locked            : high while history holds at least one window
// -----------------------------------------------------------------------------
module fft_peak_to_freq
    import fft_pkg::*;
#(
    parameter int NSamples = NSAMPLES_DEF,
    parameter int W        = W_DEF,
    parameter int NBits    = $clog2(NSamples),
    parameter int FsHz     = FSHZ_DEF,
    parameter int AvgN     = 4,
    parameter int SilenceN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     peak,
    input  logic [NBits-1:0] peak_k,
    input  logic             peak_valid,
    input  logic [W-1:0]     thresh,
    output logic [15:0]      freq_hz,
    output logic             freq_valid,
    output logic             locked
);

    localparam int PW  = NBits + 17;
    localparam int SCW = $clog2(SilenceN + 1);

    if (AvgN < 2 || AvgN > 16 || (AvgN & (AvgN - 1)) != 0) begin : g_bad_avgn
        $error("AvgN must be a power of two in 2..16");
    end

    // ---------------- S1 ----------------
    logic [1:0]       vld_q;   // [0]=S1 valid, [1]=S2 valid
    logic             s1_acc_q;
    logic [NBits-1:0] s1_k_q;

    // ---------------- S2 ----------------
    logic             s2_acc_q;
    logic [15:0]      s2_freq_q;

    // ---------------- S3 ----------------
    state_t           state_q, state_d;
    logic [SCW-1:0]   sil_q, sil_d;
    logic [15:0]      freq_hz_q, freq_hz_d;
    logic             fv_q, fv_d;
    logic [15:0]      avg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            s1_acc_q  <= 1'b0;
            s1_k_q    <= '0;
            s2_acc_q  <= 1'b0;
            s2_freq_q <= '0;
        end else begin
            vld_q     <= {vld_q[0], peak_valid};
            s1_acc_q  <= (peak >= thresh);
            s1_k_q    <= NBits'(bitrev(32'(peak_k), NBits));
            s2_acc_q  <= s1_acc_q;
            // Truncating divide by NSamples; PW bits hold k_nat*FsHz without overflow.
            s2_freq_q <= 16'((PW'(s1_k_q) * PW'(FsHz)) >> NBits);
        end
    end

`ifdef FFT_FREQ_SMOOTH_EN
    logic avg_preload, avg_update;
    assign avg_preload = vld_q[1] & s2_acc_q & (state_q == ST_EMPTY);
    assign avg_update  = vld_q[1] & s2_acc_q & (state_q == ST_TRACK);

    freq_avg #(.AvgN(AvgN)) u_avg (
        .clk       (clk),
        .reset     (reset),
        .preload_i (avg_preload),
        .update_i  (avg_update),
        .sample_i  (s2_freq_q),
        .avg_o     (avg)
    );
`else
    assign avg = s2_freq_q;
`endif

    always_comb begin
        state_d   = state_q;
        sil_d     = sil_q;
        freq_hz_d = freq_hz_q;
        fv_d      = 1'b0;
        if (vld_q[1]) begin
            if (s2_acc_q) begin
                fv_d      = 1'b1;
                freq_hz_d = avg;
                sil_d     = '0;
                state_d   = ST_TRACK;
            end else if (state_q == ST_TRACK) begin
                // Rejected while tracking: count silence, drop lock after SilenceN.
                if (sil_q == SCW'(SilenceN - 1)) begin
                    sil_d   = '0;
                    state_d = ST_EMPTY;
                end else begin
                    sil_d = sil_q + SCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            sil_q     <= '0;
            freq_hz_q <= '0;
            fv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sil_q     <= sil_d;
            freq_hz_q <= freq_hz_d;
            fv_q      <= fv_d;
        end
    end

    assign freq_hz    = freq_hz_q;
    assign freq_valid = fv_q;
    assign locked     = (state_q == ST_TRACK);

endmodule

// File: tb/tb_fft_peak_to_freq.sv
module tb_fft_peak_to_freq;

`ifdef FFT_FREQ_SMOOTH_EN
    localparam bit SMOOTH = 1'b1;
`else
    localparam bit SMOOTH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] peak;
    logic [9:0]  peak_k;
    logic        peak_valid;
    logic [32:0] thresh;
    logic [15:0] freq_hz;
    logic        freq_valid;
    logic        locked;

    fft_peak_to_freq dut (
        .clk        (clk),
        .reset      (reset),
        .peak       (peak),
        .peak_k     (peak_k),
        .peak_valid (peak_valid),
        .thresh     (thresh),
        .freq_hz    (freq_hz),
        .freq_valid (freq_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int freq;
        int lock;
        int cyc;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [9:0]  pk;
        logic [32:0] mag;
        logic [32:0] th;
        bit          acc;
        int          f_sm;
        int          f_raw;
        int          lock;
    } vec_t;
    vec_t vt [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int sm, input int raw);
        return SMOOTH ? sm : raw;
    endfunction

    // Scoreboard: every freq_valid pops one expectation including its cycle.
    always @(negedge clk) begin
        if (freq_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_freq_valid", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("freq_hz", int'(freq_hz), e.freq);
                chk("locked_at_valid", int'(locked), e.lock);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] k, input logic [32:0] m, input logic [32:0] t,
                          input bit push, input int ef, input int el);
        sb_t e;
        peak_k = k; peak = m; thresh = t; peak_valid = 1'b1;
        if (push) begin
            e.freq = ef; e.lock = el; e.cyc = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        peak_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; peak = '0; peak_k = '0; peak_valid = 1'b0; thresh = '0;

        // k_nat = bitrev10(pk); f = k_nat*48000/1024
        vt.push_back('{10'd8,    33'd5000, 33'd1000, 1'b1,  3000,  3000, 1});
        vt.push_back('{10'd4,    33'd5000, 33'd1000, 1'b1,  3750,  6000, 1});
        vt.push_back('{10'd4,    33'd5000, 33'd1000, 1'b1,  4500,  6000, 1});
        vt.push_back('{10'd4,    33'd5000, 33'd1000, 1'b1,  5250,  6000, 1});
        vt.push_back('{10'd4,    33'd5000, 33'd1000, 1'b1,  6000,  6000, 1});
        vt.push_back('{10'd4,    33'd999,  33'd1000, 1'b0,  6000,  6000, 1});
        for (int i = 0; i < 6; i++)
            vt.push_back('{10'd4, 33'd500, 33'd1000, 1'b0,  6000,  6000, 1});
        vt.push_back('{10'd4,    33'd500,  33'd1000, 1'b0,  6000,  6000, 0});
        vt.push_back('{10'd152,  33'd5000, 33'd1000, 1'b1,  4687,  4687, 1});
        vt.push_back('{10'd8,    33'd1000, 33'd1000, 1'b1,  4265,  3000, 1});
        vt.push_back('{10'd1023, 33'd5000, 33'd1000, 1'b1, 15081, 47953, 1});
        vt.push_back('{10'd0,    33'd5000, 33'd1000, 1'b1, 13910,     0, 1});

        idle(3);
        chk("reset_freq_hz", int'(freq_hz), 0);
        chk("reset_freq_valid", int'(freq_valid), 0);
        chk("reset_locked", int'(locked), 0);
        reset = 1'b0;
        idle(2);

        foreach (vt[i]) begin
            int ef;
            ef = pick(vt[i].f_sm, vt[i].f_raw);
            strobe(vt[i].pk, vt[i].mag, vt[i].th, vt[i].acc, ef, vt[i].lock);
            idle(4);
            chk($sformatf("vec%0d_freq_hz", i), int'(freq_hz), ef);
            chk($sformatf("vec%0d_locked", i), int'(locked), vt[i].lock);
        end

        // Back-to-back windows: 6000 then 4687 raw.
        strobe(10'd4,   33'd5000, 33'd1000, 1'b1, pick(14238, 6000), 1);
        strobe(10'd152, 33'd5000, 33'd1000, 1'b1, pick(14660, 4687), 1);
        idle(5);
        chk("b2b_final_freq", int'(freq_hz), pick(14660, 4687));

        // Reset one cycle after peak_valid: window must vanish.
        strobe(10'd8, 33'd5000, 33'd1000, 1'b0, 0, 0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("midrst_freq_hz", int'(freq_hz), 0);
        chk("midrst_locked", int'(locked), 0);
        idle(5);
        chk("midrst_no_valid_locked", int'(locked), 0);

        // Fresh lock after reset, then a second window.
        strobe(10'd8, 33'd5000, 33'd1000, 1'b1, 3000, 1);
        idle(4);
        chk("relock_locked", int'(locked), 1);
        strobe(10'd152, 33'd5000, 33'd1000, 1'b1, pick(3421, 4687), 1);
        idle(6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
